// File: rtl/combo_lock_pkg.sv
// combo_lock_pkg: shared definitions for the combination-lock controller.
//   - FSM state encoding (localparams plus matching enum type)
//   - digit width and button count
//   - default timing / sizing constants
//   - helper to size the shared OPEN/LOCKOUT timer
package combo_lock_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ENTRY   = 2'b01;
  localparam logic [1:0] ST_OPEN    = 2'b10;
  localparam logic [1:0] ST_LOCKOUT = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ENTRY   = ST_ENTRY,
    OPEN    = ST_OPEN,
    LOCKOUT = ST_LOCKOUT
  } state_e;

  localparam int DIGIT_W = 2;
  localparam int NUM_BTN = 4;

  localparam int DEF_CODE_LEN       = 4;
  localparam int DEF_UNLOCK_CYCLES  = 1000;
  localparam int DEF_LOCKOUT_CYCLES = 5000;
  localparam int DEF_MAX_FAILS      = 3;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Never narrower than one bit, even when both durations are 1.
  function automatic int tmr_width(input int unlock_cyc, input int lockout_cyc);
    return max_i(1, $clog2(max_i(unlock_cyc, lockout_cyc)));
  endfunction

endpackage

// File: rtl/combo_lock_edge_pulse.sv
// edge_pulse: registered rising-edge detector for one button level.
//   CLK     - clock, rising edge
//   RST     - synchronous active-high reset
//   lvl_i   - synchronised button level
//   pulse_o - high for one cycle after lvl_i is first sampled high
// History resets to 1 so a button already held during reset is not
// reported as a press when reset is released.
module edge_pulse (
  input  logic CLK,
  input  logic RST,
  input  logic lvl_i,
  output logic pulse_o
);

  logic hist_q;
  logic pulse_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hist_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      hist_q  <= lvl_i;
      pulse_q <= lvl_i & ~hist_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: collects a fixed-length button sequence, compares it with
// a programmed code and drives a timed unlock, a wrong-entry error pulse and
// (when LOCK_LOCKOUT_EN is defined) a failed-attempt lockout.
//
// Ports:
//   CLK        - clock, rising edge
//   RST        - synchronous active-high reset
//   BTN        - 4 synchronised button levels, bit i = digit i
//   CODE       - expected sequence, digit j in CODE[2j+1:2j], digit 0 first
//   UNLOCK     - registered, high while OPEN
//   ERR        - registered, one-cycle pulse when a wrong entry completes
//   LOCKED_OUT - registered, high while LOCKOUT (tied 0 without the macro)
//   DIGIT_CNT  - presses collected in the current attempt
//
// Build option: define LOCK_LOCKOUT_EN to build the fail counter and the
// LOCKOUT state. Without it a wrong entry always returns to IDLE.
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for first press, CODE tracked into code_q
// ENTRY   | collecting remaining presses against the latched code
// OPEN    | unlock asserted, timer counting down, presses ignored
// LOCKOUT | too many failures, timer counting down, presses ignored
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int  CODE_LEN       = DEF_CODE_LEN,
  parameter int  UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int  LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int  MAX_FAILS      = DEF_MAX_FAILS,
  localparam int CNT_W          = $clog2(CODE_LEN + 1)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_BTN-1:0]          BTN,
  input  logic [DIGIT_W*CODE_LEN-1:0] CODE,
  output logic                        UNLOCK,
  output logic                        ERR,
  output logic                        LOCKED_OUT,
  output logic [CNT_W-1:0]            DIGIT_CNT
);

  localparam int               TMR_W       = tmr_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(CODE_LEN);
  localparam logic [TMR_W-1:0] UNLOCK_LOAD = TMR_W'(UNLOCK_CYCLES - 1);

  logic [NUM_BTN-1:0] pulse;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_edge
    edge_pulse u_edge (
      .CLK    (CLK),
      .RST    (RST),
      .lvl_i  (BTN[i]),
      .pulse_o(pulse[i])
    );
  end

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            digit_cnt_q, cnt_d, cnt_inc;
  logic                        bad_q, bad_d, bad_upd;
  logic [TMR_W-1:0]            tmr_q, tmr_d;
  logic [DIGIT_W*CODE_LEN-1:0] code_q, code_d, cur_code;
  logic                        err_q, err_d;
  logic                        unlock_q;

  logic               press, multi, accept;
  logic [DIGIT_W-1:0] press_val, exp_digit;

  // Simultaneous pulses count as a single (bad) press; the value picked
  // then is irrelevant because the attempt is already marked bad.
  always_comb begin
    press     = |pulse;
    multi     = $countones(pulse) > 1;
    press_val = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pulse[i]) press_val = DIGIT_W'(i);
    end
  end

  // In IDLE the first press is checked against the live CODE, which is
  // latched into code_q at the same edge and held for the rest of entry.
  always_comb begin
    cur_code  = (state_q == IDLE) ? CODE : code_q;
    exp_digit = '0;
    for (int j = 0; j < CODE_LEN; j++) begin
      if (digit_cnt_q == CNT_W'(j)) exp_digit = cur_code[DIGIT_W*j +: DIGIT_W];
    end
  end

  assign accept  = press && ((state_q == IDLE) || (state_q == ENTRY));
  assign cnt_inc = digit_cnt_q + CNT_W'(1);
  assign bad_upd = bad_q | multi | (press_val != exp_digit);

`ifdef LOCK_LOCKOUT_EN
  localparam int                FAIL_W       = $clog2(MAX_FAILS + 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX     = FAIL_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0]  LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

  logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
  logic              locked_q;

  assign fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + FAIL_W'(1);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = digit_cnt_q;
    bad_d   = bad_q;
    tmr_d   = tmr_q;
    code_d  = code_q;
    err_d   = 1'b0;
`ifdef LOCK_LOCKOUT_EN
    fail_d  = fail_q;
`endif

    case (state_q)
      IDLE: begin
        code_d = CODE;
        cnt_d  = '0;
        bad_d  = 1'b0;
      end
      ENTRY: begin
      end
      OPEN: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
`ifdef LOCK_LOCKOUT_EN
      LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (cnt_inc == LAST_CNT) begin
        cnt_d = '0;
        bad_d = 1'b0;
        if (!bad_upd) begin
          state_d = OPEN;
          tmr_d   = UNLOCK_LOAD;
`ifdef LOCK_LOCKOUT_EN
          fail_d  = '0;
`endif
        end else begin
          err_d = 1'b1;
`ifdef LOCK_LOCKOUT_EN
          fail_d = fail_inc;
          if (fail_inc == FAIL_MAX) begin
            state_d = LOCKOUT;
            tmr_d   = LOCKOUT_LOAD;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end else begin
        cnt_d   = cnt_inc;
        bad_d   = bad_upd;
        state_d = ENTRY;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      digit_cnt_q <= '0;
      bad_q       <= 1'b0;
      tmr_q       <= '0;
      code_q      <= '0;
      err_q       <= 1'b0;
      unlock_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= cnt_d;
      bad_q       <= bad_d;
      tmr_q       <= tmr_d;
      code_q      <= code_d;
      err_q       <= err_d;
      unlock_q    <= (state_d == OPEN);
    end
  end

`ifdef LOCK_LOCKOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      fail_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      fail_q   <= fail_d;
      locked_q <= (state_d == LOCKOUT);
    end
  end

  assign LOCKED_OUT = locked_q;
`else
  assign LOCKED_OUT = 1'b0;
`endif

  assign UNLOCK    = unlock_q;
  assign ERR       = err_q;
  assign DIGIT_CNT = digit_cnt_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed testbench for combo_lock_ctrl with default parameters.
module tb_combo_lock_ctrl;

  localparam int CODE_LEN       = 4;
  localparam int UNLOCK_CYCLES  = 1000;
  localparam int LOCKOUT_CYCLES = 5000;
  localparam int MAX_FAILS      = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] BTN;
  logic [7:0] CODE;
  logic       UNLOCK, ERR, LOCKED_OUT;
  logic [2:0] DIGIT_CNT;

  int errors = 0;
  int checks = 0;

  combo_lock_ctrl #(
    .CODE_LEN      (CODE_LEN),
    .UNLOCK_CYCLES (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .MAX_FAILS     (MAX_FAILS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN       (BTN),
    .CODE      (CODE),
    .UNLOCK    (UNLOCK),
    .ERR       (ERR),
    .LOCKED_OUT(LOCKED_OUT),
    .DIGIT_CNT (DIGIT_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    BTN = 4'b0;
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(1);
  endtask

  // Returns one edge after the press is sampled, i.e. after the FSM acted.
  task automatic press(input int d);
    BTN    = 4'b0;
    BTN[d] = 1'b1;
    tick(1);
    BTN = 4'b0;
    tick(1);
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press(a); tick(3);
    press(b); tick(3);
    press(c); tick(3);
    press(d);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    BTN = 4'b0001;
    tick(3);
    checks++; if (UNLOCK !== 1'b0) begin errors++; $display("FAIL rst_unlock: got %b expected 0", UNLOCK); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", ERR); end
    checks++; if (LOCKED_OUT !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b expected 0", LOCKED_OUT); end
    checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", DIGIT_CNT); end
    RST = 1'b0;
    tick(3);
    checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL rst_held_btn: got %0d expected 0", DIGIT_CNT); end
    BTN = 4'b0;
    tick(2);
  endtask

  task automatic test_correct();
    int n;
    bit err_seen;
    do_reset();
    press(0);
    checks++; if (DIGIT_CNT !== 3'd1) begin errors++; $display("FAIL ok_cnt1: got %0d expected 1", DIGIT_CNT); end
    tick(3);
    press(1);
    checks++; if (DIGIT_CNT !== 3'd2) begin errors++; $display("FAIL ok_cnt2: got %0d expected 2", DIGIT_CNT); end
    tick(3);
    press(2);
    checks++; if (DIGIT_CNT !== 3'd3) begin errors++; $display("FAIL ok_cnt3: got %0d expected 3", DIGIT_CNT); end
    tick(3);
    BTN[3] = 1'b1;
    tick(1);
    checks++; if (UNLOCK !== 1'b0) begin errors++; $display("FAIL ok_early_unlock: got %b expected 0", UNLOCK); end
    BTN = 4'b0;
    tick(1);
    n = 0;
    err_seen = 1'b0;
    while (UNLOCK === 1'b1 && n < 1100) begin
      n++;
      if (ERR === 1'b1) err_seen = 1'b1;
      if (n == 100) BTN[1] = 1'b1;
      if (n == 101) BTN[1] = 1'b0;
      // pulse lands in the cycle where OPEN expires
      if (n == UNLOCK_CYCLES - 1) BTN[0] = 1'b1;
      tick(1);
    end
    BTN = 4'b0;
    checks++; if (n != UNLOCK_CYCLES) begin errors++; $display("FAIL ok_unlock_len: got %0d expected %0d", n, UNLOCK_CYCLES); end
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL ok_err: got %b expected 0", err_seen); end
    checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL ok_ignored_press: got %0d expected 0", DIGIT_CNT); end
    tick(2);
    checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL ok_idle_cnt: got %0d expected 0", DIGIT_CNT); end
  endtask

  task automatic test_wrong();
    do_reset();
    enter4(0, 1, 3, 2);
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL wrong_err: got %b expected 1", ERR); end
    checks++; if (UNLOCK !== 1'b0) begin errors++; $display("FAIL wrong_unlock: got %b expected 0", UNLOCK); end
    checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL wrong_cnt: got %0d expected 0", DIGIT_CNT); end
    tick(1);
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL wrong_err_len: got %b expected 0", ERR); end
    checks++; if (UNLOCK !== 1'b0) begin errors++; $display("FAIL wrong_unlock2: got %b expected 0", UNLOCK); end
  endtask

  task automatic test_multi();
    do_reset();
    BTN = 4'b0011;
    tick(1);
    BTN = 4'b0;
    tick(1);
    checks++; if (DIGIT_CNT !== 3'd1) begin errors++; $display("FAIL multi_cnt1: got %0d expected 1", DIGIT_CNT); end
    tick(3); press(1);
    tick(3); press(2);
    tick(3); press(3);
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL multi_err: got %b expected 1", ERR); end
    checks++; if (UNLOCK !== 1'b0) begin errors++; $display("FAIL multi_unlock: got %b expected 0", UNLOCK); end
    tick(1);
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL multi_err_len: got %b expected 0", ERR); end
  endtask

  task automatic test_hold();
    do_reset();
    BTN[0] = 1'b1;
    tick(50);
    checks++; if (DIGIT_CNT !== 3'd1) begin errors++; $display("FAIL hold_cnt: got %0d expected 1", DIGIT_CNT); end
    BTN = 4'b0;
    tick(2);
    checks++; if (DIGIT_CNT !== 3'd1) begin errors++; $display("FAIL hold_release_cnt: got %0d expected 1", DIGIT_CNT); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    BTN = 4'b0001; tick(1);
    BTN = 4'b0010; tick(1);
    checks++; if (DIGIT_CNT !== 3'd1) begin errors++; $display("FAIL b2b_cnt1: got %0d expected 1", DIGIT_CNT); end
    BTN = 4'b0100; tick(1);
    checks++; if (DIGIT_CNT !== 3'd2) begin errors++; $display("FAIL b2b_cnt2: got %0d expected 2", DIGIT_CNT); end
    BTN = 4'b1000; tick(1);
    checks++; if (DIGIT_CNT !== 3'd3) begin errors++; $display("FAIL b2b_cnt3: got %0d expected 3", DIGIT_CNT); end
    BTN = 4'b0; tick(1);
    checks++; if (UNLOCK !== 1'b1) begin errors++; $display("FAIL b2b_unlock: got %b expected 1", UNLOCK); end
    checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL b2b_cnt0: got %0d expected 0", DIGIT_CNT); end
  endtask

  task automatic test_lockout();
    int n;
    do_reset();
    for (int a = 0; a < 2; a++) begin
      enter4(1, 1, 1, 1);
      checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL lock_err%0d: got %b expected 1", a, ERR); end
      checks++; if (LOCKED_OUT !== 1'b0) begin errors++; $display("FAIL lock_early%0d: got %b expected 0", a, LOCKED_OUT); end
      tick(3);
    end
    enter4(2, 2, 2, 2);
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL lock_err2: got %b expected 1", ERR); end
`ifdef LOCK_LOCKOUT_EN
    n = 0;
    while (LOCKED_OUT === 1'b1 && n < 5200) begin
      n++;
      if (n == 10) BTN[0] = 1'b1;
      if (n == 11) BTN[0] = 1'b0;
      if (n == 20) begin
        checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL lock_press_cnt: got %0d expected 0", DIGIT_CNT); end
      end
      tick(1);
    end
    checks++; if (n != LOCKOUT_CYCLES) begin errors++; $display("FAIL lock_len: got %0d expected %0d", n, LOCKOUT_CYCLES); end
`else
    n = 0;
    repeat (5) begin
      if (LOCKED_OUT === 1'b1) n++;
      tick(1);
    end
    checks++; if (n != 0) begin errors++; $display("FAIL nolock_locked: got %0d expected 0", n); end
`endif
    tick(2);
    enter4(0, 1, 2, 3);
    checks++; if (UNLOCK !== 1'b1) begin errors++; $display("FAIL lock_after_unlock: got %b expected 1", UNLOCK); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(0); tick(3); press(1);
    checks++; if (DIGIT_CNT !== 3'd2) begin errors++; $display("FAIL rmid_cnt2: got %0d expected 2", DIGIT_CNT); end
    tick(2);
    BTN[2] = 1'b1;
    RST = 1'b1;
    tick(1);
    checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL rmid_cnt0: got %0d expected 0", DIGIT_CNT); end
    RST = 1'b0;
    tick(3);
    checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL rmid_held: got %0d expected 0", DIGIT_CNT); end
    BTN = 4'b0;
    tick(2);
    enter4(0, 1, 2, 3);
    checks++; if (UNLOCK !== 1'b1) begin errors++; $display("FAIL rmid_open: got %b expected 1", UNLOCK); end
    tick(10);
    RST = 1'b1;
    tick(1);
    checks++; if (UNLOCK !== 1'b0) begin errors++; $display("FAIL rmid_unlock0: got %b expected 0", UNLOCK); end
    RST = 1'b0;
    tick(5);
    checks++; if (UNLOCK !== 1'b0) begin errors++; $display("FAIL rmid_stay_closed: got %b expected 0", UNLOCK); end
  endtask

  initial begin
    RST  = 1'b1;
    BTN  = 4'b0;
    CODE = 8'b11_10_01_00;
    test_reset();
    test_correct();
    test_wrong();
    test_multi();
    test_hold();
    test_back_to_back();
    test_lockout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
